pair_grant_arbiter: RTL and testbench
=====================================

Name: pair_grant_arbiter

Overview:
Two-requester grant controller driving the mutually exclusive select pair (gnt_a, gnt_b) for a shared single-owner resource. Exactly one grant is high every cycle (gnt_a ^ gnt_b == 1). Ownership changes on release or after a bounded hold under contention. Sits between two requesting agents and the shared datapath. Exports a switch pulse and a switch counter for bench checking.

Parameters:
MAX_HOLD, 4, max consecutive contended cycles the owner keeps the grant; legal range 1..15.
PARK, 0, owner after reset (0 = a, 1 = b).

Ports:
clk  input  1  single clock, all state on posedge.
rst  input  1  asynchronous, active-high reset.
req_a  input  1  requester A wants the resource; level, sampled at posedge.
req_b  input  1  requester B wants the resource; level, sampled at posedge.
gnt_a  output  1  A owns the resource; registered.
gnt_b  output  1  B owns the resource; registered; always equals !gnt_a.
busy  output  1  combinational: the owner's req is high (gnt_a&req_a | gnt_b&req_b).
hold_cnt  output  4  contended cycles accumulated by the current owner.
switch  output  1  one-cycle pulse, high in the cycle after the edge that changed the owner.
sw_cnt  output  8  total ownership changes since reset; wraps 255 -> 0.

Behaviour:
- State: owner bit, hold_cnt, switch, sw_cnt; gnt_a = (owner==0), gnt_b = (owner==1).
- Reset (async, immediate, also mid-operation): owner = PARK, hold_cnt = 0, switch = 0, sw_cnt = 0. Grants stay one-hot during and after reset.
- Per posedge, with own = req of owner, oth = req of non-owner:
  - own=0, oth=0: keep owner (park), hold_cnt = 0, switch = 0.
  - own=1, oth=0: keep owner, hold_cnt = 0, switch = 0.
  - own=0, oth=1: switch owner, hold_cnt = 0, switch = 1, sw_cnt += 1.
  - own=1, oth=1, hold_cnt < MAX_HOLD-1: keep owner, hold_cnt += 1, switch = 0.
  - own=1, oth=1, hold_cnt == MAX_HOLD-1: switch owner, hold_cnt = 0, switch = 1, sw_cnt += 1.
- Latency: a req change sampled at edge N is reflected in the grants after edge N (one cycle). Grants never change between edges.
- MAX_HOLD = 1: under continuous contention, the owner alternates every cycle.
- Contention fairness: with both reqs held high, each side owns exactly MAX_HOLD consecutive cycles before handover.
- hold_cnt never exceeds MAX_HOLD-1. sw_cnt increments exactly once per switch pulse, with 8-bit wrap.
- Embedded concurrent assertions (disable iff rst): gnt_a ^ gnt_b; switch |-> gnt_a != $past(gnt_a); hold_cnt < MAX_HOLD.

Test Plan:
- Reset then idle: rst high 2 cycles, both reqs 0 for 5 cycles -> gnt_a=1, gnt_b=0, hold_cnt=0, switch=0, sw_cnt=0 throughout.
- Single requester: req_b=1 at edge 1, req_a=0 -> gnt_b=1 after edge 1, switch=1 for one cycle, sw_cnt=1. Owner then stays b with hold_cnt=0 for 10 cycles.
- Contention, MAX_HOLD=4: req_a=req_b=1 for 16 cycles starting with owner a -> grant pattern aaaabbbbaaaabbbb, hold_cnt cycles 0,1,2,3, sw_cnt=4 at end.
- MAX_HOLD=1 contention: both reqs high 6 cycles -> grants alternate every cycle, 6 switch pulses.
- Release: owner a under contention at hold_cnt=2, then req_a drops -> gnt_b=1 after the next edge, hold_cnt=0.
- Async reset mid-contention: assert rst between edges with owner b, sw_cnt=7 -> immediately gnt_a=1, sw_cnt=0, switch=0. sw_cnt wrap: 256 forced switches -> sw_cnt=0.

Source files
------------

// File: rtl/pair_grant_arbiter_if.sv
// Request/grant bundle between two agents and the pair arbiter.
// master = requester side, slave = arbiter side.
interface pair_grant_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic [3:0] hold_cnt;
  logic       switch;
  logic [7:0] sw_cnt;

  modport master (
    output req_a, req_b,
    input  gnt_a, gnt_b, busy, hold_cnt, switch, sw_cnt
  );

  modport slave (
    input  req_a, req_b,
    output gnt_a, gnt_b, busy, hold_cnt, switch, sw_cnt
  );
endinterface

// File: rtl/pair_grant_arbiter.sv
// Two-requester one-hot grant controller with bounded hold
// under contention, plus switch pulse and switch counter.
module pair_grant_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter bit PARK     = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  pair_grant_arbiter_if.slave bus
);

  logic       owner;
  logic [3:0] hold;
  logic       sw;
  logic [7:0] swc;

  logic own;
  logic oth;
  logic limit;
  logic do_sw;

  assign own   = owner ? bus.req_b : bus.req_a;
  assign oth   = owner ? bus.req_a : bus.req_b;
  assign limit = (hold == 4'(MAX_HOLD - 1));
  // Hand over on release, or when the contended hold runs out.
  assign do_sw = oth & (~own | limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= PARK;
      hold  <= 4'd0;
      sw    <= 1'b0;
      swc   <= 8'd0;
    end else begin
      sw <= do_sw;
      if (do_sw) begin
        owner <= ~owner;
        hold  <= 4'd0;
        swc   <= swc + 8'd1;
      end else if (own & oth) begin
        hold <= hold + 4'd1;
      end else begin
        hold <= 4'd0;
      end
    end
  end

  assign bus.gnt_a    = ~owner;
  assign bus.gnt_b    = owner;
  assign bus.busy     = own;
  assign bus.hold_cnt = hold;
  assign bus.switch   = sw;
  assign bus.sw_cnt   = swc;

  a_onehot: assert property (
    @(posedge clk) disable iff (rst)
    bus.gnt_a ^ bus.gnt_b);

  a_sw: assert property (
    @(posedge clk) disable iff (rst)
    sw |-> (bus.gnt_a != $past(bus.gnt_a)));

  a_hold: assert property (
    @(posedge clk) disable iff (rst)
    hold < 4'(MAX_HOLD));

endmodule

// File: tb/tb_pair_grant_arbiter.sv
// Scoreboard bench for pair_grant_arbiter: MAX_HOLD=4 and
// MAX_HOLD=1 instances share the request stimulus.
module tb_pair_grant_arbiter;

  typedef struct packed {
    logic       ga;
    logic       busy;
    logic [3:0] hc;
    logic       sw;
    logic [7:0] swc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ra  = 1'b0;
  logic rb  = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t q4[$];
  exp_t q1[$];
  bit   use1 = 1'b0;

  always #5 clk = ~clk;

  pair_grant_arbiter_if ifc4 ();
  pair_grant_arbiter_if ifc1 ();

  assign ifc4.req_a = ra;
  assign ifc4.req_b = rb;
  assign ifc1.req_a = ra;
  assign ifc1.req_b = rb;

  pair_grant_arbiter #(.MAX_HOLD(4), .PARK(1'b0)) dut4 (
    .clk(clk), .rst(rst), .bus(ifc4));

  pair_grant_arbiter #(.MAX_HOLD(1), .PARK(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1));

  function automatic exp_t mk(logic ga, logic busy,
                              int hc, logic sw, int swc);
    exp_t e;
    e.ga   = ga;
    e.busy = busy;
    e.hc   = 4'(hc);
    e.sw   = sw;
    e.swc  = 8'(swc);
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t a,
                     input logic gb, input exp_t e);
    checks++;
    if (a !== e || gb !== ~e.ga) begin
      errors++;
      $display("FAIL %s: got ga=%b gb=%b busy=%b hc=%0d sw=%b swc=%0d want ga=%b gb=%b busy=%b hc=%0d sw=%b swc=%0d",
               nm, a.ga, gb, a.busy, a.hc, a.sw, a.swc,
               e.ga, ~e.ga, e.busy, e.hc, e.sw, e.swc);
    end
  endtask

  function automatic exp_t act4();
    return '{ga: ifc4.gnt_a, busy: ifc4.busy, hc: ifc4.hold_cnt,
             sw: ifc4.switch, swc: ifc4.sw_cnt};
  endfunction

  function automatic exp_t act1();
    return '{ga: ifc1.gnt_a, busy: ifc1.busy, hc: ifc1.hold_cnt,
             sw: ifc1.switch, swc: ifc1.sw_cnt};
  endfunction

  // Monitor: outputs settle after posedge, compared at negedge.
  always @(negedge clk) begin
    if (q4.size() > 0) chk("dut4", act4(), ifc4.gnt_b, q4.pop_front());
    if (q1.size() > 0) chk("dut1", act1(), ifc1.gnt_b, q1.pop_front());
  end

  // Drive reqs mid-cycle, queue the post-edge expectation.
  task automatic step(input logic a, input logic b,
                      input exp_t e4, input exp_t e1,
                      input bit p4, input bit p1);
    @(negedge clk);
    #1;
    ra = a;
    rb = b;
    @(posedge clk);
    if (p4) q4.push_back(e4);
    if (p1) q1.push_back(e1);
  endtask

  task automatic step4(input logic a, input logic b, input exp_t e);
    step(a, b, e, e, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    ra  = 1'b0;
    rb  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_4"}, act4(), ifc4.gnt_b, mk(1, 0, 0, 0, 0));
    chk({nm, "_1"}, act1(), ifc1.gnt_b, mk(1, 0, 0, 0, 0));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int ga;

    // Reset, then idle: parked on a.
    do_reset("reset");
    for (int i = 0; i < 5; i++)
      step4(0, 0, mk(1, 0, 0, 0, 0));

    // Lone requester b takes over and keeps it.
    step4(0, 1, mk(0, 1, 0, 1, 1));
    for (int i = 0; i < 10; i++)
      step4(0, 1, mk(0, 1, 0, 0, 1));

    // Hand back to a so contention starts with owner a.
    step4(1, 0, mk(1, 1, 0, 1, 2));

    // Contention: aaaabbbbaaaabbbb, hold 0..3, four switches.
    for (int i = 1; i <= 16; i++) begin
      ga = ((i / 4) % 2 == 0) ? 1 : 0;
      if (i % 4 == 0)
        step4(1, 1, mk(ga[0], 1, 0, 1, 2 + i / 4));
      else
        step4(1, 1, mk(ga[0], 1, i % 4, 0, 2 + i / 4));
    end

    // Release at hold 2: b wins on the next edge.
    step4(1, 1, mk(1, 1, 1, 0, 6));
    step4(1, 1, mk(1, 1, 2, 0, 6));
    step4(0, 1, mk(0, 1, 0, 1, 7));
    step4(1, 1, mk(0, 1, 1, 0, 7));

    // Async reset between edges: owner b, sw_cnt 7.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", act4(), ifc4.gnt_b, mk(1, 1, 0, 0, 0));
    @(negedge clk);
    chk("async_hold", act4(), ifc4.gnt_b, mk(1, 1, 0, 0, 0));
    #1;
    rst = 1'b0;

    // MAX_HOLD=1: contention alternates owner every cycle.
    do_reset("reset1");
    for (int i = 1; i <= 6; i++)
      step(1, 1, mk(0, 0, 0, 0, 0),
           mk(i % 2 == 0, 1, 0, 1, i), 1'b0, 1'b1);

    // 256 forced switches wrap sw_cnt to 0 on both instances.
    do_reset("reset2");
    for (int k = 1; k <= 256; k++) begin
      if (k % 2 == 1)
        step(0, 1, mk(0, 1, 0, 1, k), mk(0, 1, 0, 1, k),
             1'b1, 1'b1);
      else
        step(1, 0, mk(1, 1, 0, 1, k), mk(1, 1, 0, 1, k),
             1'b1, 1'b1);
    end
    step(0, 0, mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0),
         1'b1, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q4.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got q4=%0d q1=%0d want 0",
               q4.size(), q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end want finish");
    $fatal(1, "timeout");
  end

endmodule
